// File: rtl/addsub_result_buffer_pkg.sv
// Shared packing for the 3-bit adder/subtractor result word {add, c_out, s}.
// Both the adder-side bench and the result buffer use these offsets, so a result is packed the same way everywhere.
package addsub_result_buffer_pkg;

  localparam int ADDSUB_W = 3;
  localparam int ENTRY_W  = ADDSUB_W + 2;

  // Field positions inside the packed word for the default sum width.
  localparam int S_LSB     = 0;
  localparam int C_OUT_BIT = ADDSUB_W;
  localparam int ADD_BIT   = ADDSUB_W + 1;

  typedef struct packed {
    logic                add;
    logic                c_out;
    logic [ADDSUB_W-1:0] s;
  } addsub_entry_t;

  // Width-generic versions of the offsets, for blocks built with a non-default W.
  function automatic int entry_width(input int w);
    return w + 2;
  endfunction

  function automatic int c_out_bit(input int w);
    return w;
  endfunction

  function automatic int add_bit(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/addsub_fifo_mem.sv
// Storage for the result FIFO: DEPTH x EW register array.
// It has one synchronous write port and one asynchronous read port.
module addsub_fifo_mem #(
  parameter int EW    = 5,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; the pointers and count decide what is valid, and a reset here would only add a reset net to every bit.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/addsub_result_buffer.sv
// Captures adder/subtractor results into a first-word-fall-through FIFO for a slower consumer.
// It also counts, with saturation, the results offered while the buffer was full.
module addsub_result_buffer
  import addsub_result_buffer_pkg::*;
#(
  parameter int W     = ADDSUB_W,
  parameter int DEPTH = 4,
  parameter int DCW   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_add,
  input  logic                       in_c_out,
  input  logic [W-1:0]               in_s,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_add,
  output logic                       out_c_out,
  output logic [W-1:0]               out_s,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DCW-1:0]             drop_cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int EW   = entry_width(W);
  localparam int A_B  = add_bit(W);
  localparam int C_B  = c_out_bit(W);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic [DCW-1:0] drop_q;
  logic [EW-1:0]  last_q;
  logic [EW-1:0]  head_data;
  logic [EW-1:0]  out_word;
  logic [EW-1:0]  wdata;
  logic           push;
  logic           pop;
  logic           drop_evt;

  // Handshake flags come from the registered count only, so in_valid and out_ready have no combinational path to them.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);

  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign drop_evt = in_valid & ~in_ready;
  assign wdata    = {in_add, in_c_out, in_s};

  addsub_fifo_mem #(
    .EW    (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (head_data)
  );

  // When empty, the outputs keep the last popped word; this is all-zero straight after reset.
  assign out_word  = out_valid ? head_data : last_q;
  assign out_add   = out_word[A_B];
  assign out_c_out = out_word[C_B];
  assign out_s     = out_word[W-1:0];
  assign count     = count_q;
  assign drop_cnt  = drop_q;

  // NOTE: sequential state is updated only with non-blocking assignments, so every read in this block sees the value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      last_q   <= '0;
    end else begin
      // DEPTH is a power of two, so the pointer increments wrap by themselves.
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= head_data;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop_evt && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_addsub_result_buffer.sv
// Directed bench for addsub_result_buffer: the stimulus queues each expected result, and a monitor compares every pop against that queue.
module tb_addsub_result_buffer;
  import addsub_result_buffer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_add, in_c_out;
  logic [2:0] in_s;
  logic       in_ready, out_valid, out_ready;
  logic       out_add, out_c_out;
  logic [2:0] out_s;
  logic [2:0] count;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  addsub_entry_t sb[$];

  always #5 clk = ~clk;

  addsub_result_buffer #(.W(3), .DEPTH(4), .DCW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_add    (in_add),
    .in_c_out  (in_c_out),
    .in_s      (in_s),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_add   (out_add),
    .out_c_out (out_c_out),
    .out_s     (out_s),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake that is set up at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {out_add, out_c_out, out_s}, 32'hFFFF);
      end else begin
        check("output_word", {out_add, out_c_out, out_s}, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic a, input logic c, input logic [2:0] s,
                       input logic rdy, input logic expect_accept);
    in_valid  = v;
    in_add    = a;
    in_c_out  = c;
    in_s      = s;
    out_ready = rdy;
    if (expect_accept) sb.push_back('{add: a, c_out: c, s: s});
    step();
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 1'b0, 3'd0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_add    = 1'b0;
    in_c_out  = 1'b0;
    in_s      = '0;
    out_ready = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_out_word", {out_add, out_c_out, out_s}, 0);

    // Single result: latency 1 edge, then held stable while out_ready=0
    drive(1'b1, 1'b1, 1'b0, 3'b101, 1'b0, 1'b1);
    idle(1'b0);
    check("single_valid", out_valid, 1);
    check("single_s", out_s, 5);
    check("single_count", count, 1);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      check("single_stable", {out_add, out_c_out, out_s}, 5'b10101);
    end
    idle(1'b1);
    check("single_drained", out_valid, 0);

    // Fill and drop: six offers, four accepted
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, i[0], i[1], i[2:0], 1'b0, i <= 4);
    end
    idle(1'b0);
    check("fill_count", count, 4);
    check("fill_in_ready", in_ready, 0);
    check("fill_drop", drop_cnt, 2);
    repeat (4) idle(1'b1);
    idle(1'b0);
    check("fill_drained", out_valid, 0);
    check("fill_drained_cnt", count, 0);

    // Full with a simultaneous offer and pop: the offer is dropped, the pop happens
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, i[2:0], 1'b0, 1'b1);
    end
    drive(1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0);
    check("fullpp_count", count, 3);
    check("fullpp_drop", drop_cnt, 3);
    drive(1'b1, 1'b1, 1'b0, 3'd6, 1'b0, 1'b1);
    check("fullpp_next_count", count, 4);
    check("fullpp_next_drop", drop_cnt, 3);
    repeat (4) idle(1'b1);
    idle(1'b0);
    check("fullpp_drained", out_valid, 0);

    // Wrap and streaming: the pointers wrap several times while count stays 1
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, i[0], i[1], 3'(i % 8), 1'b1, 1'b1);
      check("stream_count", count, 1);
    end
    idle(1'b1);
    idle(1'b0);
    check("stream_drained", count, 0);
    check("stream_drop", drop_cnt, 0);

    // drop_cnt saturates at 255 and does not wrap
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b0, 1'b0, 3'(i), 1'b0, i < 4);
    end
    check("sat_drop", drop_cnt, 255);
    repeat (4) idle(1'b1);
    idle(1'b0);
    check("sat_drained", out_valid, 0);

    // Async reset between edges with three entries held
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 3'(i + 2), 1'b0, 1'b1);
    end
    in_valid = 1'b0;
    check("midrst_pre_count", count, 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_valid", out_valid, 0);
    check("midrst_count", count, 0);
    check("midrst_drop", drop_cnt, 0);
    check("midrst_out_word", {out_add, out_c_out, out_s}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check("midrst_no_output", out_valid, 0);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
